// File: rtl/mem_types_pkg.sv
// Shared types for the cacheline-to-burst memory bridge.
// Line, beat, FSM state and client encodings.
package mem_types_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } bridge_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } client_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the icache/dcache line ports.
// grant is one-hot: bit 0 icache, bit 1 dcache.
module rr_arb2
    import mem_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    client_e last_grant;

    // Pick the requester; on a tie favour the one not served last.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b11:   grant = (last_grant == ICACHE) ? 2'b10 : 2'b01;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember who won whenever a grant is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= ICACHE;
        end else if (take && (|req)) begin
            last_grant <= grant[1] ? DCACHE : ICACHE;
        end
    end

endmodule

// File: rtl/pmem_line_bridge.sv
// Arbitrates icache/dcache line requests onto a 4-beat pmem burst port.
// One line transaction in flight; line register assembles or sources beats.
module pmem_line_bridge
    import mem_types_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic                 i_read,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic [ADDR_BITS-1:0] pmem_address,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [BEAT_BITS-1:0] pmem_wdata,
    input  logic [BEAT_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int BW = $clog2(BEATS);
    localparam logic [ADDR_BITS-1:0] OFF_MASK =
        ADDR_BITS'(LINE_BITS / 8 - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    bridge_state_e        state;
    client_e              owner;
    logic                 is_wr;
    logic [BW-1:0]        beat;
    logic [LINE_BITS-1:0] line;
    logic [1:0]           req;
    logic [1:0]           grant;
    logic                 arb_take;

    assign req      = {d_read | d_write, i_read};
    assign arb_take = (state == IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .take  (arb_take),
        .grant (grant)
    );

    // Current write beat is sliced straight out of the held line.
    assign pmem_wdata = pmem_write
        ? line[int'(beat)*BEAT_BITS +: BEAT_BITS]
        : '0;

    // Read data is only presented during the completion pulse.
    assign i_rdata = (i_resp && !is_wr) ? line : '0;
    assign d_rdata = (d_resp && !is_wr) ? line : '0;

    // Grant, burst sequencing and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= ICACHE;
            is_wr        <= 1'b0;
            beat         <= '0;
            line         <= '0;
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    beat <= '0;
                    if (grant[1]) begin
                        owner        <= DCACHE;
                        pmem_address <= d_addr & ~OFF_MASK;
                        if (d_write) begin
                            is_wr      <= 1'b1;
                            line       <= d_wdata;
                            pmem_write <= 1'b1;
                            state      <= WR_BURST;
                        end else begin
                            is_wr     <= 1'b0;
                            pmem_read <= 1'b1;
                            state     <= RD_BURST;
                        end
                    end else if (grant[0]) begin
                        owner        <= ICACHE;
                        pmem_address <= i_addr & ~OFF_MASK;
                        is_wr        <= 1'b0;
                        pmem_read    <= 1'b1;
                        state        <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (pmem_resp) begin
                        line[int'(beat)*BEAT_BITS +: BEAT_BITS] <= pmem_rdata;
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            pmem_read <= 1'b0;
                            i_resp    <= (owner == ICACHE);
                            d_resp    <= (owner == DCACHE);
                            state     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (pmem_resp) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            pmem_write <= 1'b0;
                            i_resp     <= (owner == ICACHE);
                            d_resp     <= (owner == DCACHE);
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_line_bridge.sv
// Bench for pmem_line_bridge: randomized line traffic against a memory model.
// Reference tracks line contents and round-robin order at transaction level.
module tb_pmem_line_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    pmem_line_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .i_read       (i_read),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_addr       (d_addr),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        bit           is_d;
        logic [255:0] data;
    } resp_t;

    typedef struct {
        int          cyc;
        bit          is_wr;
        logic [31:0] addr;
    } burst_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [255:0] mem_env [8];
    logic [255:0] ref_mem [8];
    bit           last_d = 1'b0;

    int  mem_lat = 0;
    bit  stray_en = 1'b0;
    int  proto_err = 0;
    int  both_resp = 0;
    int  rd_cycles = 0;

    bit           m_busy = 1'b0;
    int           m_wait;
    int           m_beat;
    logic [31:0]  m_addr;
    bit           m_wr;
    logic [255:0] cap;

    resp_t        rq [$];
    burst_t       bq [$];
    logic [255:0] wq [$];
    bit           prev_act = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Burst memory: mem_lat wait cycles, then four consecutive beats.
    always @(negedge clk) begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (!rst) begin
            m_busy = 1'b0;
        end else begin
            if (!m_busy && (pmem_read || pmem_write)) begin
                m_busy = 1'b1;
                m_wait = mem_lat;
                m_beat = 0;
                m_addr = pmem_address;
                m_wr   = pmem_write;
                cap    = '0;
            end
            if (m_busy) begin
                if (!(pmem_read || pmem_write) || (pmem_read && pmem_write)
                    || pmem_address !== m_addr || pmem_write !== m_wr)
                    proto_err++;
                if (m_wait > 0) begin
                    m_wait--;
                end else begin
                    pmem_resp = 1'b1;
                    if (m_wr) cap[m_beat*64 +: 64] = pmem_wdata;
                    else pmem_rdata = mem_env[m_addr[7:5]][m_beat*64 +: 64];
                    m_beat++;
                    if (m_beat == 4) begin
                        m_busy = 1'b0;
                        if (m_wr) begin
                            mem_env[m_addr[7:5]] = cap;
                            wq.push_back(cap);
                        end
                    end
                end
            end else if (stray_en) begin
                pmem_resp  = 1'($urandom_range(0, 1));
                pmem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Record completions and burst starts with their cycle numbers.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (i_resp && d_resp) both_resp++;
            if (i_resp) rq.push_back(resp_t'{cyc, 1'b0, i_rdata});
            if (d_resp) rq.push_back(resp_t'{cyc, 1'b1, d_rdata});
            if ((pmem_read || pmem_write) && !prev_act)
                bq.push_back(burst_t'{cyc, pmem_write, pmem_address});
            if (pmem_read) rd_cycles++;
        end
        prev_act = (rst === 1'b1) && (pmem_read || pmem_write);
    end

    // Clients drop their request right after their completion pulse.
    always @(negedge clk) begin
        if (i_resp === 1'b1) i_read = 1'b0;
        if (d_resp === 1'b1) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_q();
        rq.delete();
        bq.delete();
        wq.delete();
    endtask

    task automatic do_reset();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        rst = 1'b0;
        steps(2);
        rst = 1'b1;
        last_d = 1'b0;
        steps(1);
        clear_q();
    endtask

    task automatic wait_rq(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (rq.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (rq.size() >= n);
    endtask

    function automatic logic [31:0] mk_addr(input logic [2:0] idx);
        logic [31:0] r;
        r = $urandom;
        return {r[31:8], idx, r[4:0]};
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        steps(2);
        n_vec++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {pmem_read, pmem_write, i_resp, d_resp});
        end
        n_vec++;
        if (pmem_address !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr got=%h exp=0", pmem_address);
        end
        n_vec++;
        if ({i_rdata, d_rdata, pmem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data got nonzero exp=0");
        end
        rst = 1'b1;
        last_d = 1'b0;
        stray_en = 1'b1;
        steps(6);
        stray_en = 1'b0;
        n_vec++;
        if (bq.size() + rq.size() != 0) begin
            n_err++;
            $display("FAIL reset_idle got=%0d events exp=0",
                     bq.size() + rq.size());
        end
        clear_q();
    endtask

    task automatic test_icache_read();
        int n0;
        bit ok;
        logic [255:0] exp;
        exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        mem_env[3] = exp;
        ref_mem[3] = exp;
        mem_lat = 2;
        clear_q();
        i_addr = 32'h60;
        i_read = 1'b1;
        n0 = cyc;
        wait_rq(1, 40, ok);
        n_vec++;
        if (!ok || bq.size() != 1) begin
            n_err++;
            $display("FAIL iread_timeout got=%0d resp exp=1", rq.size());
        end else begin
            n_vec++;
            if (bq[0].addr !== 32'h60 || bq[0].is_wr !== 1'b0) begin
                n_err++;
                $display("FAIL iread_addr got=%h/%b exp=00000060/0",
                         bq[0].addr, bq[0].is_wr);
            end
            n_vec++;
            if (bq[0].cyc != n0 + 1) begin
                n_err++;
                $display("FAIL iread_start got=%0d exp=%0d", bq[0].cyc, n0 + 1);
            end
            n_vec++;
            if (rq[0].is_d !== 1'b0 || rq[0].data !== exp) begin
                n_err++;
                $display("FAIL iread_data got=%h exp=%h", rq[0].data, exp);
            end
            n_vec++;
            if (rq[0].cyc != n0 + 7) begin
                n_err++;
                $display("FAIL iread_lat got=%0d exp=%0d", rq[0].cyc, n0 + 7);
            end
        end
        last_d = 1'b0;
        steps(3);
        n_vec++;
        if (rq.size() != 1) begin
            n_err++;
            $display("FAIL iread_pulse got=%0d exp=1", rq.size());
        end
    endtask

    task automatic test_dcache_write();
        int n0;
        bit ok;
        logic [255:0] w;
        w = rnd_line();
        mem_lat = 1;
        clear_q();
        d_addr  = 32'h1234_567F;
        d_wdata = w;
        d_write = 1'b1;
        n0 = cyc;
        wait_rq(1, 40, ok);
        n_vec++;
        if (!ok || bq.size() != 1 || wq.size() != 1) begin
            n_err++;
            $display("FAIL dwrite_timeout got=%0d resp exp=1", rq.size());
        end else begin
            n_vec++;
            if (bq[0].addr !== 32'h1234_5660 || bq[0].is_wr !== 1'b1) begin
                n_err++;
                $display("FAIL dwrite_addr got=%h/%b exp=12345660/1",
                         bq[0].addr, bq[0].is_wr);
            end
            n_vec++;
            if (wq[0] !== w) begin
                n_err++;
                $display("FAIL dwrite_beats got=%h exp=%h", wq[0], w);
            end
            n_vec++;
            if (rq[0].is_d !== 1'b1 || rq[0].data !== '0) begin
                n_err++;
                $display("FAIL dwrite_resp got=%b/%h exp=1/0",
                         rq[0].is_d, rq[0].data);
            end
            n_vec++;
            if (rq[0].cyc != n0 + 6) begin
                n_err++;
                $display("FAIL dwrite_lat got=%0d exp=%0d", rq[0].cyc, n0 + 6);
            end
        end
        ref_mem[3] = w;
        last_d = 1'b1;
        steps(3);
        n_vec++;
        if (rq.size() != 1) begin
            n_err++;
            $display("FAIL dwrite_pulse got=%0d exp=1", rq.size());
        end
    endtask

    task automatic test_alternate();
        bit ok;
        int n0;
        do_reset();
        mem_lat = 0;
        for (int rep = 0; rep < 2; rep++) begin
            clear_q();
            i_addr = mk_addr(3'd1);
            d_addr = mk_addr(3'd2);
            i_read = 1'b1;
            d_read = 1'b1;
            n0 = cyc;
            wait_rq(2, 60, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL alt_timeout got=%0d resp exp=2", rq.size());
            end else begin
                n_vec++;
                if (rq[0].is_d !== 1'b1 || rq[1].is_d !== 1'b0) begin
                    n_err++;
                    $display("FAIL alt_order got=%b%b exp=10",
                             rq[0].is_d, rq[1].is_d);
                end
                n_vec++;
                if (rq[0].data !== ref_mem[2] || rq[1].data !== ref_mem[1]) begin
                    n_err++;
                    $display("FAIL alt_data got=%h exp=%h", rq[0].data, ref_mem[2]);
                end
                n_vec++;
                if (rq[0].cyc != n0 + 5 || rq[1].cyc != n0 + 11) begin
                    n_err++;
                    $display("FAIL alt_lat got=%0d,%0d exp=%0d,%0d",
                             rq[0].cyc, rq[1].cyc, n0 + 5, n0 + 11);
                end
            end
            steps(3);
        end
        n_vec++;
        if (both_resp != 0) begin
            n_err++;
            $display("FAIL alt_both_resp got=%0d exp=0", both_resp);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit ok;
        mem_lat = 0;
        clear_q();
        i_addr = mk_addr(3'd5);
        i_read = 1'b1;
        k = 0;
        while (!(m_busy && m_beat == 3) && k < 30) begin
            step();
            k++;
        end
        n_vec++;
        if (!(m_busy && m_beat == 3)) begin
            n_err++;
            $display("FAIL rstmid_beat2 got=%0d exp=3", m_beat);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
            n_err++;
            $display("FAIL rstmid_drop got=%b exp=0000",
                     {pmem_read, pmem_write, i_resp, d_resp});
        end
        i_read = 1'b0;
        steps(2);
        rst = 1'b1;
        last_d = 1'b0;
        steps(2);
        n_vec++;
        if (rq.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_noresp got=%0d exp=0", rq.size());
        end
        clear_q();
        mem_lat = 1;
        i_read = 1'b1;
        wait_rq(1, 40, ok);
        steps(3);
        n_vec++;
        if (!ok || rq.size() != 1 || bq.size() != 1 || rq[0].data !== ref_mem[5]) begin
            n_err++;
            $display("FAIL rstmid_clean got=%0d resp exp=1", rq.size());
        end
    endtask

    task automatic test_latency();
        int n0;
        int lat;
        bit ok;
        for (int t = 0; t < 2; t++) begin
            lat = (t == 0) ? 0 : 7;
            mem_lat = lat;
            stray_en = 1'b1;
            clear_q();
            d_addr = mk_addr(3'd4);
            d_read = 1'b1;
            n0 = cyc;
            wait_rq(1, 40, ok);
            n_vec++;
            if (!ok || rq[0].cyc != n0 + 5 + lat || rq[0].data !== ref_mem[4]) begin
                n_err++;
                $display("FAIL lat%0d got=%0d exp=%0d", lat,
                         ok ? rq[0].cyc : -1, n0 + 5 + lat);
            end
            last_d = 1'b1;
            steps(2);
            clear_q();
            steps(16);
            n_vec++;
            if (bq.size() + rq.size() != 0 || pmem_read || pmem_write) begin
                n_err++;
                $display("FAIL stray%0d got=%0d events exp=0", lat,
                         bq.size() + rq.size());
            end
            stray_en = 1'b0;
        end
    endtask

    task automatic test_rw_both();
        bit ok;
        logic [255:0] w;
        w = rnd_line();
        mem_lat = 3;
        clear_q();
        rd_cycles = 0;
        d_addr = mk_addr(3'd6);
        d_wdata = w;
        d_read = 1'b1;
        d_write = 1'b1;
        wait_rq(1, 40, ok);
        steps(3);
        n_vec++;
        if (!ok || rd_cycles != 0 || bq.size() != 1 || bq[0].is_wr !== 1'b1) begin
            n_err++;
            $display("FAIL rw_both got=%0d read cycles exp=0", rd_cycles);
        end
        n_vec++;
        if (wq.size() != 1 || wq[0] !== w || rq[0].data !== '0) begin
            n_err++;
            $display("FAIL rw_both_data got=%0d writes exp=1", wq.size());
        end
        ref_mem[6] = w;
        last_d = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int pat;
            int lat;
            int op;
            int nexp;
            int n0;
            int wi;
            bit ok;
            bit use_i;
            bit use_d;
            bit dr;
            bit dw;
            logic [2:0] ii;
            logic [2:0] di;
            logic [31:0] ia;
            logic [31:0] da;
            logic [255:0] wd;
            bit ord_d [2];
            bit exp_wr [2];
            logic [31:0] exp_addr [2];
            logic [255:0] exp_data [2];
            pat = $urandom_range(1, 3);
            use_i = pat[0];
            use_d = pat[1];
            lat = $urandom_range(0, 7);
            mem_lat = lat;
            stray_en = 1'($urandom_range(0, 1));
            ii = 3'($urandom_range(0, 7));
            di = 3'($urandom_range(0, 7));
            ia = mk_addr(ii);
            da = mk_addr(di);
            op = $urandom_range(0, 2);
            dr = (op != 1);
            dw = (op != 0);
            wd = rnd_line();
            if (use_i && use_d) begin
                ord_d[0] = !last_d;
                ord_d[1] = last_d;
                nexp = 2;
            end else begin
                ord_d[0] = use_d;
                ord_d[1] = 1'b0;
                last_d = use_d;
                nexp = 1;
            end
            for (int k = 0; k < nexp; k++) begin
                if (ord_d[k]) begin
                    exp_addr[k] = da & ~32'h1F;
                    exp_wr[k] = dw;
                    if (dw) begin
                        exp_data[k] = '0;
                        ref_mem[di] = wd;
                    end else begin
                        exp_data[k] = ref_mem[di];
                    end
                end else begin
                    exp_addr[k] = ia & ~32'h1F;
                    exp_wr[k] = 1'b0;
                    exp_data[k] = ref_mem[ii];
                end
            end
            clear_q();
            i_addr = ia;
            d_addr = da;
            d_wdata = wd;
            i_read = use_i;
            d_read = use_d && dr;
            d_write = use_d && dw;
            n0 = cyc;
            wait_rq(nexp, 80, ok);
            steps(3);
            n_vec++;
            if (!ok || rq.size() != nexp || bq.size() != nexp) begin
                n_err++;
                $display("FAIL rnd%0d_count got=%0d exp=%0d", it, rq.size(), nexp);
            end else begin
                wi = 0;
                for (int k = 0; k < nexp; k++) begin
                    n_vec++;
                    if (rq[k].is_d !== ord_d[k] || rq[k].data !== exp_data[k]) begin
                        n_err++;
                        $display("FAIL rnd%0d_resp%0d got=%b/%h exp=%b/%h", it, k,
                                 rq[k].is_d, rq[k].data, ord_d[k], exp_data[k]);
                    end
                    n_vec++;
                    if (bq[k].addr !== exp_addr[k] || bq[k].is_wr !== exp_wr[k]) begin
                        n_err++;
                        $display("FAIL rnd%0d_burst%0d got=%h/%b exp=%h/%b", it, k,
                                 bq[k].addr, bq[k].is_wr, exp_addr[k], exp_wr[k]);
                    end
                    n_vec++;
                    if (rq[k].cyc != n0 + 5 + lat + k * (6 + lat)) begin
                        n_err++;
                        $display("FAIL rnd%0d_lat%0d got=%0d exp=%0d", it, k,
                                 rq[k].cyc, n0 + 5 + lat + k * (6 + lat));
                    end
                    if (exp_wr[k]) begin
                        n_vec++;
                        if (wi >= wq.size() || wq[wi] !== wd) begin
                            n_err++;
                            $display("FAIL rnd%0d_wbeats got=%0d writes exp=%h",
                                     it, wq.size(), wd);
                        end
                        wi++;
                    end
                end
            end
            stray_en = 1'b0;
        end
    endtask

    task automatic test_protocol();
        n_vec++;
        if (proto_err != 0) begin
            n_err++;
            $display("FAIL burst_protocol got=%0d errors exp=0", proto_err);
        end
        n_vec++;
        if (both_resp != 0) begin
            n_err++;
            $display("FAIL dual_resp got=%0d exp=0", both_resp);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            mem_env[k] = rnd_line();
            ref_mem[k] = mem_env[k];
        end
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_alternate();
        test_reset_mid();
        test_latency();
        test_rw_both();
        test_random();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
